// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter
// Shares one data-memory port between instruction fetch (IF) and the memory
// stage (M). A winner is picked in IDLE, its transaction is registered onto
// the memory bus, and the arbiter waits for mem_ready_i or a timeout. A
// one-cycle acknowledge then goes back to the winner. Misaligned requests
// never reach memory and are acknowledged with misalign_err_o.
module dmem_port_arbiter #(
  parameter int unsigned TIMEOUT = 16  // wait-cycle limit, 0 disables abort
) (
  input  logic        clk,
  input  logic        rst_n,
  // fetch port (always a word read)
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  output logic        if_ack_o,
  output logic [31:0] if_rdata_o,
  // M-stage port
  input  logic        m_req_i,
  input  logic [31:0] m_addr_i,
  input  logic [1:0]  m_read_en_i,
  input  logic [1:0]  m_write_en_i,
  input  logic [31:0] m_wdata_i,
  output logic        m_ack_o,
  output logic [31:0] m_rdata_o,
  // memory bus
  output logic        mem_valid_o,
  output logic [31:0] mem_addr_o,
  output logic [1:0]  mem_read_en_o,
  output logic [1:0]  mem_write_en_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ready_i,
  input  logic [31:0] mem_rdata_i,
  // status
  output logic        misalign_err_o,
  output logic        timeout_err_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ERR
  } state_e;

  typedef enum logic {
    GR_IF,
    GR_M
  } grant_e;

  // Wait-counter value at which a stalled transaction is aborted.
  localparam logic [31:0] TimeoutLast = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

  state_e      state_q;
  grant_e      last_grant_q;
  logic [31:0] wait_cnt_q;
  logic        busy_q;
  logic        if_ack_q,  m_ack_q;
  logic [31:0] if_rdata_q, m_rdata_q;
  logic        misalign_q, timeout_q;
  logic        mem_valid_q;
  logic [31:0] mem_addr_q;
  logic [1:0]  mem_read_en_q, mem_write_en_q;
  logic [31:0] mem_wdata_q;

  logic        if_elig, m_elig;
  logic        pick_m, pick_if;
  logic [31:0] sel_addr, sel_wdata;
  logic [1:0]  sel_rd, sel_wr, sel_size, m_size;
  logic        sel_misal;
  logic [31:0] ack_rdata_d;
  logic        timeout_hit;

  // Arbitration, request selection and alignment check for the IDLE grant.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned and no latch is inferred.
    sel_addr  = if_addr_i;
    sel_rd    = 2'b11;
    sel_wr    = 2'b00;
    sel_wdata = 32'd0;
    sel_size  = 2'b11;
    sel_misal = 1'b0;

    // A requester acknowledged this cycle is not eligible at this edge.
    if_elig = if_req_i & ~if_ack_q;
    m_elig  = m_req_i & ~m_ack_q;
    // M has priority unless it won last time and fetch is waiting.
    pick_m  = m_elig & ~((last_grant_q == GR_M) & if_elig);
    pick_if = if_elig & ~pick_m;

    m_size = (m_read_en_i != 2'b00) ? m_read_en_i : m_write_en_i;

    if (pick_m) begin
      sel_addr  = m_addr_i;
      sel_rd    = m_read_en_i;
      sel_wr    = m_write_en_i;
      sel_wdata = m_wdata_i;
      sel_size  = m_size;
    end

    case (sel_size)
      2'b10:   sel_misal = sel_addr[0];
      2'b11:   sel_misal = |sel_addr[1:0];
      default: sel_misal = 1'b0;
    endcase
  end

  // Completion data and timeout condition for the transaction in flight.
  always_comb begin
    ack_rdata_d = (mem_read_en_q != 2'b00) ? mem_rdata_i : 32'd0;
    timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == TimeoutLast);
  end

  // Arbiter FSM with all bus, acknowledge and status outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the bus fields are reset asynchronously too, so a reset in mid-transaction takes mem_valid down at once and leaves nothing on the bus.
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      last_grant_q   <= GR_IF;
      wait_cnt_q     <= 32'd0;
      busy_q         <= 1'b0;
      if_ack_q       <= 1'b0;
      m_ack_q        <= 1'b0;
      if_rdata_q     <= 32'd0;
      m_rdata_q      <= 32'd0;
      misalign_q     <= 1'b0;
      timeout_q      <= 1'b0;
      mem_valid_q    <= 1'b0;
      mem_addr_q     <= 32'd0;
      mem_read_en_q  <= 2'b00;
      mem_write_en_q <= 2'b00;
      mem_wdata_q    <= 32'd0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every read here sees the pre-edge value.
      // Acknowledge, data and error flags are one-cycle pulses by default.
      if_ack_q   <= 1'b0;
      m_ack_q    <= 1'b0;
      if_rdata_q <= 32'd0;
      m_rdata_q  <= 32'd0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (pick_m || pick_if) begin
            last_grant_q <= pick_m ? GR_M : GR_IF;
            busy_q       <= 1'b1;
            if (sel_misal) begin
              state_q <= ST_ERR;
            end else begin
              mem_valid_q    <= 1'b1;
              mem_addr_q     <= sel_addr;
              mem_read_en_q  <= sel_rd;
              mem_write_en_q <= sel_wr;
              mem_wdata_q    <= sel_wdata;
              wait_cnt_q     <= 32'd0;
              state_q        <= ST_BUSY;
            end
          end
        end

        ST_BUSY: begin
          if (mem_ready_i || timeout_hit) begin
            if (last_grant_q == GR_M) begin
              m_ack_q   <= 1'b1;
              m_rdata_q <= mem_ready_i ? ack_rdata_d : 32'd0;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_ready_i ? ack_rdata_d : 32'd0;
            end
            timeout_q      <= ~mem_ready_i;
            mem_valid_q    <= 1'b0;
            mem_addr_q     <= 32'd0;
            mem_read_en_q  <= 2'b00;
            mem_write_en_q <= 2'b00;
            mem_wdata_q    <= 32'd0;
            busy_q         <= 1'b0;
            state_q        <= ST_IDLE;
          end else if (wait_cnt_q != 32'hFFFF_FFFF) begin
            wait_cnt_q <= wait_cnt_q + 32'd1;
          end
        end

        ST_ERR: begin
          if (last_grant_q == GR_M) begin
            m_ack_q <= 1'b1;
          end else begin
            if_ack_q <= 1'b1;
          end
          misalign_q <= 1'b1;
          busy_q     <= 1'b0;
          state_q    <= ST_IDLE;
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign if_ack_o       = if_ack_q;
  assign if_rdata_o     = if_rdata_q;
  assign m_ack_o        = m_ack_q;
  assign m_rdata_o      = m_rdata_q;
  assign mem_valid_o    = mem_valid_q;
  assign mem_addr_o     = mem_addr_q;
  assign mem_read_en_o  = mem_read_en_q;
  assign mem_write_en_o = mem_write_en_q;
  assign mem_wdata_o    = mem_wdata_q;
  assign misalign_err_o = misalign_q;
  assign timeout_err_o  = timeout_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: randomized requesters and memory, checked
// every cycle against a transaction-level model that predicts, for each
// grant, the mem_valid window, the acknowledge cycle and the returned data.
module tb_dmem_port_arbiter;

  localparam int unsigned TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        m_req = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [1:0]  m_read_en = 2'b00;
  logic [1:0]  m_write_en = 2'b00;
  logic [31:0] m_wdata = 32'd0;
  logic        m_ack;
  logic [31:0] m_rdata;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [1:0]  mem_read_en;
  logic [1:0]  mem_write_en;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        misalign_err;
  logic        timeout_err;
  logic        busy;

  dmem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_req_i       (if_req),
    .if_addr_i      (if_addr),
    .if_ack_o       (if_ack),
    .if_rdata_o     (if_rdata),
    .m_req_i        (m_req),
    .m_addr_i       (m_addr),
    .m_read_en_i    (m_read_en),
    .m_write_en_i   (m_write_en),
    .m_wdata_i      (m_wdata),
    .m_ack_o        (m_ack),
    .m_rdata_o      (m_rdata),
    .mem_valid_o    (mem_valid),
    .mem_addr_o     (mem_addr),
    .mem_read_en_o  (mem_read_en),
    .mem_write_en_o (mem_write_en),
    .mem_wdata_o    (mem_wdata),
    .mem_ready_i    (mem_ready),
    .mem_rdata_i    (mem_rdata),
    .misalign_err_o (misalign_err),
    .timeout_err_o  (timeout_err),
    .busy_o         (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        is_m;
    logic [31:0] addr;
    logic [1:0]  rd;
    logic [1:0]  wr;
    logic [31:0] wdata;
  } req_t;

  // One granted transaction as the model sees it.
  typedef struct {
    bit          active;
    req_t        r;
    bit          misal;
    bit          tmo;
    int          grant_c;
    int          ready_c;
    int          valid_end;
    int          ack_c;
    logic [31:0] rdata_mem;
  } txn_t;

  int          cyc = 0;
  int unsigned total = 0;
  int unsigned bad = 0;

  txn_t        cur;
  bit          last_m;
  bit          rq_on [2];
  req_t        rq [2];
  req_t        force_if [$];
  req_t        force_m [$];
  int          wait_q [$];
  logic [31:0] data_q [$];

  int          req_pct, mis_pct, wait_max, tmo_pct, noise_pct;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic bit misaligned(input req_t r);
    logic [1:0] sz;
    sz = r.is_m ? ((r.rd != 2'b00) ? r.rd : r.wr) : 2'b11;
    if (sz == 2'b11) return (r.addr[1] | r.addr[0]);
    if (sz == 2'b10) return r.addr[0];
    return 1'b0;
  endfunction

  function automatic req_t rand_req(input bit is_m);
    req_t       r;
    logic [1:0] sz;
    r = '0;
    r.is_m = is_m;
    r.addr = $urandom;
    if ($urandom_range(0, 99) >= mis_pct) r.addr[1:0] = 2'b00;
    if (is_m) begin
      sz = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 1) == 1) r.rd = sz;
      else r.wr = sz;
      r.wdata = $urandom;
    end else begin
      r.rd = 2'b11;
    end
    return r;
  endfunction

  function automatic req_t mk_req(input bit is_m, input logic [31:0] addr,
                                  input logic [1:0] rd, input logic [1:0] wr,
                                  input logic [31:0] wdata);
    req_t r;
    r.is_m = is_m; r.addr = addr; r.rd = rd; r.wr = wr; r.wdata = wdata;
    return r;
  endfunction

  // Predict the whole life of a transaction granted in the current cycle.
  task automatic start_txn(input req_t r);
    int w;
    cur.active    = 1'b1;
    cur.r         = r;
    cur.grant_c   = cyc;
    cur.misal     = misaligned(r);
    cur.tmo       = 1'b0;
    cur.ready_c   = -1;
    cur.rdata_mem = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
    if (cur.misal) begin
      cur.valid_end = cyc;
      cur.ack_c     = cyc + 2;
    end else begin
      if (wait_q.size() > 0) w = wait_q.pop_front();
      else if ($urandom_range(0, 99) < tmo_pct) w = int'(TIMEOUT) + int'($urandom_range(0, 4));
      else w = int'($urandom_range(0, wait_max));
      if (TIMEOUT == 0 || w < int'(TIMEOUT)) begin
        cur.ready_c   = cyc + 1 + w;
        cur.valid_end = cur.ready_c;
        cur.ack_c     = cur.ready_c + 1;
      end else begin
        cur.tmo       = 1'b1;
        cur.valid_end = cyc + int'(TIMEOUT);
        cur.ack_c     = cur.valid_end + 1;
      end
    end
  endtask

  // One clock cycle: check outputs, update requesters, drive memory, grant.
  task automatic step();
    bit          exp_v, exp_b, exp_a, ack_m, ack_if, el_if, el_m, win_m;
    logic [1:0]  rd_e;
    logic [31:0] rd_exp;
    @(negedge clk);
    cyc++;
    exp_v  = cur.active && !cur.misal && cyc > cur.grant_c && cyc <= cur.valid_end;
    exp_b  = cur.active && cyc > cur.grant_c && cyc < cur.ack_c;
    exp_a  = cur.active && cyc == cur.ack_c;
    ack_m  = exp_a && cur.r.is_m;
    ack_if = exp_a && !cur.r.is_m;
    rd_e   = cur.r.is_m ? cur.r.rd : 2'b11;
    rd_exp = (!cur.misal && !cur.tmo && rd_e != 2'b00) ? cur.rdata_mem : 32'd0;

    check("mem_valid", {31'd0, mem_valid}, {31'd0, exp_v});
    check("mem_addr", mem_addr, exp_v ? cur.r.addr : 32'd0);
    check("mem_read_en", {30'd0, mem_read_en}, {30'd0, (exp_v ? rd_e : 2'b00)});
    check("mem_write_en", {30'd0, mem_write_en}, {30'd0, ((exp_v && cur.r.is_m) ? cur.r.wr : 2'b00)});
    check("mem_wdata", mem_wdata, (exp_v && cur.r.is_m) ? cur.r.wdata : 32'd0);
    check("busy", {31'd0, busy}, {31'd0, exp_b});
    check("if_ack", {31'd0, if_ack}, {31'd0, ack_if});
    check("m_ack", {31'd0, m_ack}, {31'd0, ack_m});
    check("misalign_err", {31'd0, misalign_err}, {31'd0, (exp_a && cur.misal)});
    check("timeout_err", {31'd0, timeout_err}, {31'd0, (exp_a && cur.tmo)});
    if (ack_if) check("if_rdata", if_rdata, rd_exp);
    if (ack_m) check("m_rdata", m_rdata, rd_exp);

    // Requesters drop after their ack and may re-request in the same cycle.
    for (int i = 0; i < 2; i++) begin
      if ((i == 0 && ack_if) || (i == 1 && ack_m)) rq_on[i] = 1'b0;
      if (!rq_on[i]) begin
        if (i == 0 && force_if.size() > 0) begin
          rq[0] = force_if.pop_front(); rq_on[0] = 1'b1;
        end else if (i == 1 && force_m.size() > 0) begin
          rq[1] = force_m.pop_front(); rq_on[1] = 1'b1;
        end else if ($urandom_range(0, 99) < req_pct) begin
          rq[i] = rand_req(i == 1); rq_on[i] = 1'b1;
        end
      end
    end

    // Memory: complete on the chosen cycle; stray ready only when idle.
    if (exp_v && cyc == cur.ready_c) begin
      mem_ready = 1'b1;
      mem_rdata = cur.rdata_mem;
    end else begin
      mem_ready = !exp_v && rst_n && ($urandom_range(0, 99) < noise_pct);
      mem_rdata = $urandom;
    end

    // Grant rule: M first, unless M won last and fetch is waiting.
    if (rst_n && (!cur.active || cyc >= cur.ack_c)) begin
      el_if = rq_on[0] && !ack_if;
      el_m  = rq_on[1] && !ack_m;
      if (el_m || el_if) begin
        win_m = el_m && !(last_m && el_if);
        start_txn(win_m ? rq[1] : rq[0]);
        last_m = win_m;
      end
    end

    if_req     = rq_on[0];
    if_addr    = rq[0].addr;
    m_req      = rq_on[1];
    m_addr     = rq[1].addr;
    m_read_en  = rq[1].rd;
    m_write_en = rq[1].wr;
    m_wdata    = rq[1].wdata;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic drain();
    req_pct = 0;
    run(60);
  endtask

  task automatic model_reset();
    cur.active = 1'b0;
    last_m     = 1'b0;
    wait_q.delete();
    data_q.delete();
  endtask

  initial begin
    cur.active = 1'b0; cur.r = '0; cur.misal = 1'b0; cur.tmo = 1'b0;
    cur.grant_c = 0; cur.ready_c = -1; cur.valid_end = 0; cur.ack_c = 0; cur.rdata_mem = 32'd0;
    last_m = 1'b0;
    rq_on[0] = 1'b0; rq_on[1] = 1'b0;
    rq[0] = '0; rq[1] = '0;
    req_pct = 0; mis_pct = 0; wait_max = 0; tmo_pct = 0; noise_pct = 30;

    // Reset state.
    run(3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(3);

    // Zero-wait M word read returning 0xDEADBEEF.
    force_m.push_back(mk_req(1'b1, 32'h100, 2'b11, 2'b00, 32'd0));
    wait_q.push_back(0);
    data_q.push_back(32'hDEADBEEF);
    run(8);

    // Both requesters held continuously, zero-wait: alternating grants.
    req_pct = 100; mis_pct = 0; wait_max = 0; tmo_pct = 0;
    run(24);
    drain();

    // Misaligned half store.
    force_m.push_back(mk_req(1'b1, 32'h203, 2'b00, 2'b10, 32'h1234_5678));
    run(8);

    // Fetch with 3 wait cycles.
    force_if.push_back(mk_req(1'b0, 32'h40, 2'b11, 2'b00, 32'd0));
    wait_q.push_back(3);
    run(10);

    // Fetch that never sees mem_ready: timeout abort.
    force_if.push_back(mk_req(1'b0, 32'h44, 2'b11, 2'b00, 32'd0));
    wait_q.push_back(40);
    run(24);

    // Ready on the last allowed cycle, then one cycle too late.
    force_m.push_back(mk_req(1'b1, 32'h300, 2'b11, 2'b00, 32'd0));
    force_if.push_back(mk_req(1'b0, 32'h48, 2'b11, 2'b00, 32'd0));
    wait_q.push_back(int'(TIMEOUT) - 1);
    wait_q.push_back(int'(TIMEOUT));
    run(45);
    drain();

    // Reset while a transaction is on the bus.
    force_m.push_back(mk_req(1'b1, 32'h400, 2'b11, 2'b00, 32'd0));
    wait_q.push_back(10);
    run(4);
    #1 rst_n = 1'b0;
    #1;
    check("rst_mem_valid", {31'd0, mem_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_m_ack", {31'd0, m_ack}, 32'd0);
    check("rst_if_ack", {31'd0, if_ack}, 32'd0);
    model_reset();
    mem_ready = 1'b0;
    force_if.push_back(mk_req(1'b0, 32'h800, 2'b11, 2'b00, 32'd0));
    run(3);
    @(posedge clk);
    #1 rst_n = 1'b1;
    run(20);
    drain();

    // Randomized traffic under several profiles.
    for (int p = 0; p < 4; p++) begin
      req_pct   = (p == 0) ? 100 : 40 + 15 * p;
      mis_pct   = (p == 2) ? 40 : 10;
      wait_max  = (p == 0) ? 0 : 2 + 2 * p;
      tmo_pct   = (p == 3) ? 15 : 3;
      noise_pct = 30;
      run(500);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single data-memory port between instruction fetch and the memory stage. It arbitrates requests, registers the granted transaction onto the memory bus, and waits on a variable-latency memory's ready signal. It returns read data to the winner with a one-cycle acknowledge. It sits between the pipeline (fetch unit, M stage) and the external memory. Misaligned accesses and memory timeouts are detected and reported.

## Interface
- TIMEOUT, 16: max cycles a granted transaction waits for mem_ready before abort; 0 disables the timeout.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset; all state and outputs clear immediately
- if_req  in  1  fetch request; held with if_addr stable until if_ack
- if_addr  in  32  fetch address (always word read)
- if_ack  out  1  one-cycle completion pulse to fetch
- if_rdata  out  32  instruction word, valid while if_ack=1
- m_req  in  1  M-stage request; held with fields stable until m_ack
- m_addr  in  32  load/store address
- m_read_en  in  2  00 none, 01 byte, 10 half, 11 word
- m_write_en  in  2  same encoding; exactly one of read/write nonzero when m_req=1
- m_wdata  in  32  store data
- m_ack  out  1  one-cycle completion pulse to M stage
- m_rdata  out  32  raw load data, valid while m_ack=1; 0 for stores
- mem_valid  out  1  transaction presented to memory
- mem_addr  out  32  registered address
- mem_read_en  out  2  registered read size
- mem_write_en  out  2  registered write size
- mem_wdata  out  32  registered store data
- mem_ready  in  1  memory completes the presented transaction this cycle
- mem_rdata  in  32  memory read data, valid with mem_ready
- misalign_err  out  1  pulse with ack when the request was misaligned
- timeout_err  out  1  pulse with ack when the transaction was aborted by timeout
- busy  out  1  registered; 1 whenever state is not IDLE

## Operation
- FSM states:
  - IDLE
  - BUSY: a transaction is presented to memory.
  - ERR: a misaligned request is being acknowledged.
- Eligibility: a requester is eligible when req=1 and its own ack=0 this cycle. A requester acknowledged this cycle is never re-granted at the same edge.
- Arbitration in IDLE: M wins over IF, except when last_grant=M and IF is eligible; then IF wins. last_grant updates at every grant and resets to IF.
- Alignment check at grant:
  - Half accesses need addr[0]=0.
  - Word accesses (including all fetches) need addr[1:0]=0.
  - On failure: no memory access is issued; go to ERR.
- Grant with alignment OK:
  - Register addr/read_en/write_en/wdata onto mem_* (fetch: read_en=11, write_en=00, wdata=0).
  - Set mem_valid=1, clear wait counter, go to BUSY.
- BUSY, mem_ready=1:
  - mem_valid<=0; winner's ack<=1.
  - rdata<=mem_rdata for reads, 0 for stores.
  - Go to IDLE.
- BUSY, mem_ready=0: the counter increments. When the counter reaches TIMEOUT-1 with TIMEOUT≠0:
  - mem_valid<=0; ack<=1, rdata<=0, timeout_err<=1.
  - Go to IDLE.
- ERR: ack<=1, rdata<=0, misalign_err<=1; go to IDLE.
- mem_* fields hold their values while mem_valid=1. They return to 0 when mem_valid drops.
- Counter is 32-bit saturating internally and compared against TIMEOUT.

## Timing
- Reset values: all outputs 0; state IDLE; last_grant=IF; counter 0.
- Minimum latency, zero-wait memory:
  - req seen in IDLE at edge N → mem_valid=1 in cycle N+1.
  - mem_ready=1 in N+1 → ack=1 in cycle N+2.
  - Total: 2 cycles.
- Each wait cycle adds 1 cycle to the latency.
- Misaligned request: ack in cycle N+2, with no mem_valid.
- ack, rdata, misalign_err and timeout_err are registered. ack and each err flag are high for exactly one cycle.
- Back-to-back: the cycle ack=1 is IDLE. The other requester may be granted at that edge, giving one transaction per 2 cycles at zero wait.
- mem_ready while mem_valid=0 is ignored.
- Timeout abort with TIMEOUT=16: mem_valid is high for 16 cycles, then ack follows in the next cycle.
- rst_n low mid-transaction: mem_valid drops asynchronously, no ack is produced, and the interrupted transaction is lost.

## Test plan
- m_req word read of 0x100 in IDLE, mem_ready same cycle mem_valid rises, mem_rdata=0xDEADBEEF → m_ack and m_rdata=0xDEADBEEF 2 cycles after the request edge; if_ack stays 0.
- if_req and m_req held continuously with zero-wait memory → grants alternate M,IF,M,IF; every second cycle an ack occurs; first grant is M.
- m_req half store to 0x203 → no mem_valid; m_ack=1 and misalign_err=1 in the same cycle 2 cycles after the request; m_rdata=0.
- Fetch with mem_ready delayed 3 cycles → mem_valid high 4 cycles, mem_addr stable throughout, if_ack on the cycle after mem_ready.
- TIMEOUT=16, mem_ready never asserted → mem_valid high 16 cycles; then if_ack=1, timeout_err=1, if_rdata=0; busy returns to 0.
- rst_n pulled low while in BUSY with mem_valid=1 → mem_valid, busy and all acks 0 immediately; after release, the first grant goes to M when both requesters are pending.
